mips_decode_stage: RTL and testbench

Instruction-decode stage of the five-stage MIPS pipeline. Takes the IF/ID instruction word and PC+4, and produces:
- two register operands from a 32×32 register file;
- the sign-extended immediate;
- the branch target;
- an equality flag for early branch resolution;
- the opcode and funct fields for the main controller.

The register-file write port is driven from the write-back stage.

---
 rtl/mips_decode_stage_if.sv | 28 ++
 rtl/mips_decode_stage.sv | 56 +++++
 tb/tb_mips_decode_stage.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mips_decode_stage_if.sv
// Signal bundle for the MIPS ID stage: write-back port, IF/ID inputs and decode outputs.
// The master side drives the stage; the slave side is the decode stage itself.
interface mips_decode_stage_if;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data_reg;
    logic [31:0] instruction;
    logic [31:0] pc_plus4;
    logic [31:0] read_data1_reg;
    logic [31:0] read_data2_reg;
    logic [31:0] inst_extended;
    logic [31:0] branch_adder_id;
    logic [5:0]  opcode;
    logic [5:0]  func;
    logic        zero;

    modport master (
        output reg_write, write_reg, write_data_reg, instruction, pc_plus4,
        input  read_data1_reg, read_data2_reg, inst_extended, branch_adder_id,
               opcode, func, zero
    );

    modport slave (
        input  reg_write, write_reg, write_data_reg, instruction, pc_plus4,
        output read_data1_reg, read_data2_reg, inst_extended, branch_adder_id,
               opcode, func, zero
    );
endinterface

// File: rtl/mips_decode_stage.sv
// MIPS instruction-decode stage: 32x32 register file with write-through bypass,
// sign extension, branch-target adder, operand equality flag and field slicing.
module mips_decode_stage (
    input  logic                 clk,
    input  logic                 rst,
    mips_decode_stage_if.slave   dif
);
    logic [31:0] regs [32];
    logic [4:0]  rs_idx;
    logic [4:0]  rt_idx;
    logic        wr_en;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic signed [31:0] imm_sext;

    assign rs_idx = dif.instruction[25:21];
    assign rt_idx = dif.instruction[20:16];

    // Writes (and therefore bypass) are suppressed for r0 and while reset is held.
    assign wr_en = dif.reg_write && (dif.write_reg != 5'd0) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (wr_en) begin
            regs[dif.write_reg] <= dif.write_data_reg;
        end
    end

    always_comb begin
        rd1 = 32'd0;
        if (rs_idx != 5'd0) begin
            rd1 = (wr_en && (dif.write_reg == rs_idx)) ? dif.write_data_reg : regs[rs_idx];
        end
    end

    always_comb begin
        rd2 = 32'd0;
        if (rt_idx != 5'd0) begin
            rd2 = (wr_en && (dif.write_reg == rt_idx)) ? dif.write_data_reg : regs[rt_idx];
        end
    end

    assign imm_sext = 32'(signed'(dif.instruction[15:0]));

    assign dif.read_data1_reg  = rd1;
    assign dif.read_data2_reg  = rd2;
    assign dif.zero            = (rd1 == rd2);
    assign dif.inst_extended   = imm_sext;
    // Word offset: the <<2 is pure wiring; the sum wraps modulo 2^32.
    assign dif.branch_adder_id = dif.pc_plus4 + {imm_sext[29:0], 2'b00};
    assign dif.opcode          = dif.instruction[31:26];
    assign dif.func            = dif.instruction[5:0];
endmodule

// File: tb/tb_mips_decode_stage.sv
// Directed testbench for mips_decode_stage with hand-computed expected values.
module tb_mips_decode_stage;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;

    mips_decode_stage_if dif ();

    mips_decode_stage dut (
        .clk (clk),
        .rst (rst),
        .dif (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_inst(input logic [4:0] rs, input logic [4:0] rt,
                                            input logic [15:0] imm);
        return {6'd0, rs, rt, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] idx, input logic [31:0] data);
        dif.reg_write      = 1'b1;
        dif.write_reg      = idx;
        dif.write_data_reg = data;
        tick();
        dif.reg_write      = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst = 1'b1;
        dif.reg_write      = 1'b0;
        dif.write_reg      = 5'd0;
        dif.write_data_reg = 32'd0;
        dif.instruction    = mk_inst(5'd3, 5'd4, 16'd0);
        dif.pc_plus4       = 32'd0;
        #2;
        chk("rst_rd1", dif.read_data1_reg, 32'd0);
        chk("rst_rd2", dif.read_data2_reg, 32'd0);
        chk("rst_zero", {31'd0, dif.zero}, 32'd1);
        tick();
        rst = 1'b0;
        #1;

        // write r5, observe bypass in the write cycle and stored value afterwards
        dif.instruction    = mk_inst(5'd5, 5'd0, 16'd0);
        dif.reg_write      = 1'b1;
        dif.write_reg      = 5'd5;
        dif.write_data_reg = 32'hDEADBEEF;
        #1;
        chk("r5_bypass", dif.read_data1_reg, 32'hDEADBEEF);
        tick();
        dif.reg_write = 1'b0;
        #1;
        chk("r5_rd1", dif.read_data1_reg, 32'hDEADBEEF);
        chk("r5_rd2", dif.read_data2_reg, 32'd0);
        chk("r5_zero", {31'd0, dif.zero}, 32'd0);

        // r0 write must neither bypass nor stick
        dif.instruction    = mk_inst(5'd0, 5'd5, 16'd0);
        dif.reg_write      = 1'b1;
        dif.write_reg      = 5'd0;
        dif.write_data_reg = 32'h12345678;
        #1;
        chk("r0_nobypass", dif.read_data1_reg, 32'd0);
        tick();
        dif.reg_write = 1'b0;
        #1;
        chk("r0_after", dif.read_data1_reg, 32'd0);
        chk("r0_rt_r5", dif.read_data2_reg, 32'hDEADBEEF);

        // same-cycle bypass on both ports
        dif.instruction    = mk_inst(5'd7, 5'd7, 16'd0);
        dif.reg_write      = 1'b1;
        dif.write_reg      = 5'd7;
        dif.write_data_reg = 32'hA5A5A5A5;
        #1;
        chk("byp_rd1", dif.read_data1_reg, 32'hA5A5A5A5);
        chk("byp_rd2", dif.read_data2_reg, 32'hA5A5A5A5);
        chk("byp_zero", {31'd0, dif.zero}, 32'd1);
        tick();
        dif.reg_write = 1'b0;
        dif.instruction = mk_inst(5'd7, 5'd5, 16'd0);
        #1;
        chk("r7_stored", dif.read_data1_reg, 32'hA5A5A5A5);
        chk("r7_r5_zero", {31'd0, dif.zero}, 32'd0);

        // equal values in different registers
        wr(5'd12, 32'hA5A5A5A5);
        dif.instruction = mk_inst(5'd7, 5'd12, 16'd0);
        #1;
        chk("eq_zero", {31'd0, dif.zero}, 32'd1);

        // preload, then asynchronous reset mid-cycle
        wr(5'd1, 32'h11111111);
        wr(5'd31, 32'hFFFFFFFF);
        dif.instruction = mk_inst(5'd1, 5'd31, 16'd0);
        #1;
        chk("pre_r1", dif.read_data1_reg, 32'h11111111);
        chk("pre_r31", dif.read_data2_reg, 32'hFFFFFFFF);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_r1", dif.read_data1_reg, 32'd0);
        chk("arst_r31", dif.read_data2_reg, 32'd0);
        chk("arst_zero", {31'd0, dif.zero}, 32'd1);
        dif.instruction = mk_inst(5'd5, 5'd7, 16'd0);
        #1;
        chk("arst_r5", dif.read_data1_reg, 32'd0);
        chk("arst_r7", dif.read_data2_reg, 32'd0);

        // write held across reset: blocked (no bypass) until rst falls
        dif.instruction    = mk_inst(5'd9, 5'd0, 16'd0);
        dif.reg_write      = 1'b1;
        dif.write_reg      = 5'd9;
        dif.write_data_reg = 32'h0BADF00D;
        #1;
        chk("rst_nobypass", dif.read_data1_reg, 32'd0);
        tick();
        dif.reg_write = 1'b0;
        #1;
        chk("rst_blocked", dif.read_data1_reg, 32'd0);
        dif.reg_write = 1'b1;
        rst = 1'b0;
        tick();
        dif.reg_write = 1'b0;
        #1;
        chk("post_rst_wr", dif.read_data1_reg, 32'h0BADF00D);

        // sign extension and branch target
        dif.instruction = mk_inst(5'd0, 5'd0, 16'hFFFE);
        dif.pc_plus4    = 32'h00000100;
        #1;
        chk("sext_neg", dif.inst_extended, 32'hFFFFFFFE);
        chk("br_back", dif.branch_adder_id, 32'h000000F8);
        dif.instruction = mk_inst(5'd0, 5'd0, 16'h0004);
        dif.pc_plus4    = 32'hFFFFFFFC;
        #1;
        chk("sext_pos", dif.inst_extended, 32'h00000004);
        chk("br_wrap", dif.branch_adder_id, 32'h0000000C);
        dif.instruction = mk_inst(5'd0, 5'd0, 16'h8000);
        dif.pc_plus4    = 32'h00040000;
        #1;
        chk("sext_min", dif.inst_extended, 32'hFFFF8000);
        chk("br_min", dif.branch_adder_id, 32'h00020000);

        // field decode: add $8,$9,$10
        wr(5'd9, 32'h00000009);
        wr(5'd10, 32'h0000000A);
        dif.instruction = 32'h012A4020;
        #1;
        chk("fd_opcode", {26'd0, dif.opcode}, 32'h00000000);
        chk("fd_func", {26'd0, dif.func}, 32'h00000020);
        chk("fd_rs", dif.read_data1_reg, 32'h00000009);
        chk("fd_rt", dif.read_data2_reg, 32'h0000000A);
        chk("fd_zero", {31'd0, dif.zero}, 32'd0);
        chk("fd_sext", dif.inst_extended, 32'h00004020);
        dif.instruction = 32'h8D2A0010;
        #1;
        chk("lw_opcode", {26'd0, dif.opcode}, 32'h00000023);
        chk("lw_func", {26'd0, dif.func}, 32'h00000010);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
